// File: rtl/icache_resp.sv
// ----------------------------------------------------------------------------
// icache_resp
// Instruction-side responder for the fetch stage. Direct-mapped, read-only
// cache. It answers a fetch one cycle after the request, in step with decode,
// and keeps at most one line refill outstanding on the memory port. When a
// refill completes it pulses a per-thread wake mask so that threads put to
// sleep by a miss can replay their fetch.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   i_addr/i_rd/i_trd fetch request: byte address, strobe, thread id
//   inv               pulse: invalidate every line
//   i_data            instruction word, valid the cycle after the request
//   i_miss            response-cycle pulse: line not resident
//   i_segfault        response-cycle pulse: address illegal or misaligned
//   fill_wake         one-cycle pulse: threads to wake after a refill
//   busy              refill in progress
//   mem_rd/mem_addr   line read request (held until mem_gnt) and line address
//   mem_gnt           memory accepted the request
//   mem_rvalid/rdata  refill beats, word 0 first
//   perf_hit/miss     hit and miss response counters (ICACHE_PERF_EN only)
//
// Build option: define ICACHE_PERF_EN to add the perf_hit/perf_miss counters.
// ----------------------------------------------------------------------------
module icache_resp #(
  parameter int          LINES      = 64,
  parameter int          LINE_WORDS = 4,
  parameter logic [31:0] SEG_BASE   = 32'h0000_0000,
  parameter logic [31:0] SEG_LIMIT  = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic        i_rd,
  input  logic [2:0]  i_trd,
  input  logic        inv,
  output logic [31:0] i_data,
  output logic        i_miss,
  output logic        i_segfault,
  output logic [7:0]  fill_wake,
  output logic        busy,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] perf_hit,
  output logic [31:0] perf_miss
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_DONE} state_t;

  state_t           state;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [31:0]      data_arr [LINES*LINE_WORDS];
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [OFF_W-1:0] beat;
  logic [7:0]       waitmask;
  logic             inv_pend;   // inv seen during this refill: do not mark valid

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             seg;
  logic             hit;
  logic             miss_now;
  logic [7:0]       trd_bit;
  logic [31:0]      rd_word;

  assign req_off  = i_addr[OFF_W+1:2];
  assign req_idx  = i_addr[OFF_W+2 +: IDX_W];
  assign req_tag  = i_addr[31 -: TAG_W];
  // Modular distance from the base turns the two-sided range test into one
  // unsigned compare (assumes SEG_LIMIT > SEG_BASE).
  assign seg      = ((i_addr - SEG_BASE) >= (SEG_LIMIT - SEG_BASE)) ||
                    (i_addr[1:0] != 2'b00);
  assign hit      = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign miss_now = i_rd && !seg && !hit;
  assign trd_bit  = 8'b1 << i_trd;
  assign rd_word  = data_arr[{req_idx, req_off}];

  // Fetch response, one cycle after the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_data     <= '0;
      i_miss     <= 1'b0;
      i_segfault <= 1'b0;
    end else begin
      i_miss     <= 1'b0;
      i_segfault <= 1'b0;
      if (i_rd) begin
        if (seg) begin
          i_segfault <= 1'b1;
          i_data     <= '0;
        end else if (hit) begin
          i_data     <= rd_word;
        end else begin
          i_miss     <= 1'b1;
          i_data     <= '0;
        end
      end
    end
  end

  // Refill FSM, valid bits and waiting-thread mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      busy      <= 1'b0;
      fill_idx  <= '0;
      fill_tag  <= '0;
      beat      <= '0;
      waitmask  <= '0;
      fill_wake <= '0;
      valid     <= '0;
      inv_pend  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (miss_now) begin
          state    <= S_REQ;
          mem_rd   <= 1'b1;
          busy     <= 1'b1;
          mem_addr <= {req_tag, req_idx, {(OFF_W+2){1'b0}}};
          fill_idx <= req_idx;
          fill_tag <= req_tag;
        end
        S_REQ: if (mem_gnt) begin
          state  <= S_FILL;
          mem_rd <= 1'b0;
        end
        S_FILL: if (mem_rvalid) begin
          beat <= beat + OFF_W'(1);   // wraps to 0 after the last beat
          if (beat == OFF_W'(LINE_WORDS-1)) state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      fill_wake <= (state == S_DONE) ? waitmask : 8'h00;

      // A miss in the DONE cycle belongs to the next refill's wake set.
      if (state == S_DONE)
        waitmask <= miss_now ? trd_bit : 8'h00;
      else if (miss_now)
        waitmask <= waitmask | trd_bit;

      if (state == S_DONE)
        inv_pend <= 1'b0;
      else if (inv && state != S_IDLE)
        inv_pend <= 1'b1;

      // The victim line is dropped as its refill starts, since its words are
      // overwritten beat by beat; it only becomes valid again after DONE.
      if (inv) begin
        valid <= '0;
      end else begin
        if (state == S_IDLE && miss_now) valid[req_idx] <= 1'b0;
        if (state == S_DONE && !inv_pend) valid[fill_idx] <= 1'b1;
      end
    end
  end

  // Storage arrays carry no reset; the valid bits gate every read.
  always_ff @(posedge clk) begin
    if (state == S_FILL && mem_rvalid) data_arr[{fill_idx, beat}] <= mem_rdata;
    if (state == S_DONE) tag_arr[fill_idx] <= fill_tag;
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hit  <= '0;
      perf_miss <= '0;
    end else if (i_rd && !seg) begin
      if (hit) perf_hit  <= perf_hit + 32'd1;
      else     perf_miss <= perf_miss + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_resp.sv
// ----------------------------------------------------------------------------
// tb_icache_resp
// Directed scenarios followed by a randomized fetch stream for icache_resp.
// The reference model holds resident lines as an index -> tag map and
// derives memory contents from a fixed address hash, so expected fetch data
// comes from the address alone.
// ----------------------------------------------------------------------------
module tb_icache_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr;
  logic        i_rd;
  logic [2:0]  i_trd;
  logic        inv;
  logic [31:0] i_data;
  logic        i_miss;
  logic        i_segfault;
  logic [7:0]  fill_wake;
  logic        busy;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit;
  logic [31:0] perf_miss;
`endif

  icache_resp dut (
    .clk(clk), .rst(rst), .i_addr(i_addr), .i_rd(i_rd), .i_trd(i_trd),
    .inv(inv), .i_data(i_data), .i_miss(i_miss), .i_segfault(i_segfault),
    .fill_wake(fill_wake), .busy(busy), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef ICACHE_PERF_EN
    , .perf_hit(perf_hit), .perf_miss(perf_miss)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: resident line per index.
  bit          mvalid [64];
  logic [31:0] mtag   [64];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a ^ 32'h5A5A_0000) * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input logic [31:0] d, input logic m, input logic s);
    chk({tag, "_data"}, i_data, d);
    chk({tag, "_miss"}, {31'd0, i_miss}, {31'd0, m});
    chk({tag, "_seg"},  {31'd0, i_segfault}, {31'd0, s});
  endtask

  task automatic fetch(input logic [31:0] a, input logic [2:0] t);
    i_rd = 1'b1; i_addr = a; i_trd = t;
    cyc();
    i_rd = 1'b0;
  endtask

  task automatic beat(input logic [31:0] line, input int w);
    mem_rvalid = 1'b1;
    mem_rdata  = mem_word(line + 32'(w * 4));
    cyc();
    mem_rvalid = 1'b0;
  endtask

  task automatic inv_pulse();
    inv = 1'b1;
    cyc();
    inv = 1'b0;
  endtask

  // Full refill of one line, optionally with random grant delay and beat gaps.
  task automatic serve(input logic [31:0] line, input bit rnd);
    int n = 0;
    int g;
    while (mem_rd !== 1'b1 && n < 16) begin cyc(); n++; end
    chk("mem_rd_req", {31'd0, mem_rd}, 32'd1);
    chk("mem_addr", mem_addr, line);
    g = rnd ? $urandom_range(0, 3) : 0;
    repeat (g) cyc();
    chk("mem_rd_held", {31'd0, mem_rd}, 32'd1);
    mem_gnt = 1'b1;
    cyc();
    mem_gnt = 1'b0;
    for (int w = 0; w < 4; w++) begin
      g = rnd ? $urandom_range(0, 2) : 0;
      repeat (g) cyc();
      beat(line, w);
    end
  endtask

  task automatic expect_wake(input string tag, input logic [7:0] exp);
    int n = 0;
    while (fill_wake === 8'h00 && n < 8) begin cyc(); n++; end
    chk(tag, {24'd0, fill_wake}, {24'd0, exp});
    cyc();
    chk("wake_one_cycle", {24'd0, fill_wake}, 32'd0);
    chk("busy_after_fill", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] pool [6] = '{32'h0000, 32'h0400, 32'h0100, 32'hFFF0, 32'h8100, 32'h1230};
  logic [31:0] a, last_data, exp_d;
  logic [2:0]  t;
  int          idx, k;
  bit          exp_seg, exp_hit;

  initial begin
    rst = 1'b1; i_addr = '0; i_rd = 1'b0; i_trd = '0; inv = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) cyc();
    chk_resp("reset", 32'd0, 1'b0, 1'b0);
    chk("reset_wake", {24'd0, fill_wake}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    cyc();

    // Cold fetch from thread 2.
    fetch(32'h100, 3'd2);
    chk_resp("cold", 32'd0, 1'b1, 1'b0);
    chk("cold_busy", {31'd0, busy}, 32'd1);
    serve(32'h100, 1'b0);
    expect_wake("cold_wake", 8'h04);
    fetch(32'h104, 3'd2);
    chk_resp("hit_104", mem_word(32'h104), 1'b0, 1'b0);
    cyc();
    chk_resp("idle_hold", mem_word(32'h104), 1'b0, 1'b0);

    // Segment and alignment faults.
    fetch(32'h0001_0000, 3'd0);
    chk_resp("seg_limit", 32'd0, 1'b0, 1'b1);
    chk("seg_no_mem_rd", {31'd0, mem_rd}, 32'd0);
    fetch(32'h102, 3'd0);
    chk_resp("seg_align", 32'd0, 1'b0, 1'b1);
    cyc();
    chk("seg_no_busy", {31'd0, busy}, 32'd0);

    // Misses from other threads while a refill is in flight.
    inv_pulse();
    fetch(32'h100, 3'd2);
    chk_resp("mf_first", 32'd0, 1'b1, 1'b0);
    mem_gnt = 1'b1; cyc(); mem_gnt = 1'b0;
    beat(32'h100, 0);
    i_rd = 1'b1; i_addr = 32'h100; i_trd = 3'd5;
    beat(32'h100, 1);
    i_rd = 1'b0;
    chk_resp("mf_trd5", 32'd0, 1'b1, 1'b0);
    i_rd = 1'b1; i_addr = 32'h400; i_trd = 3'd1;
    beat(32'h100, 2);
    i_rd = 1'b0;
    chk_resp("mf_trd1", 32'd0, 1'b1, 1'b0);
    chk("mf_no_new_req", {31'd0, mem_rd}, 32'd0);
    beat(32'h100, 3);
    expect_wake("mf_wake", 8'h26);
    chk("mf_single_refill", {31'd0, mem_rd}, 32'd0);
    fetch(32'h100, 3'd5);
    chk_resp("mf_replay5", mem_word(32'h100), 1'b0, 1'b0);
    fetch(32'h400, 3'd1);
    chk_resp("mf_replay1", 32'd0, 1'b1, 1'b0);
    serve(32'h400, 1'b0);
    expect_wake("mf_wake400", 8'h02);
    fetch(32'h408, 3'd1);
    chk_resp("hit_408", mem_word(32'h408), 1'b0, 1'b0);

    // Invalidate during a fill: wake still fires, line stays invalid.
    inv_pulse();
    fetch(32'h100, 3'd3);
    chk_resp("inv_miss", 32'd0, 1'b1, 1'b0);
    mem_gnt = 1'b1; cyc(); mem_gnt = 1'b0;
    beat(32'h100, 0);
    inv = 1'b1;
    beat(32'h100, 1);
    inv = 1'b0;
    beat(32'h100, 2);
    beat(32'h100, 3);
    expect_wake("inv_wake", 8'h08);
    fetch(32'h100, 3'd3);
    chk_resp("inv_refetch", 32'd0, 1'b1, 1'b0);

    // Reset in the middle of that refill.
    chk("pre_rst_addr", mem_addr, 32'h100);
    mem_gnt = 1'b1; cyc(); mem_gnt = 1'b0;
    beat(32'h100, 0);
    beat(32'h100, 1);
    #2 rst = 1'b1;
    #1;
    chk_resp("rst_mid", 32'd0, 1'b0, 1'b0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_addr", mem_addr, 32'd0);
    chk("rst_mid_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_mid_wake", {24'd0, fill_wake}, 32'd0);
    cyc();
    rst = 1'b0;
    beat(32'h100, 2);
    beat(32'h100, 3);
    cyc();
    chk("late_beat_busy", {31'd0, busy}, 32'd0);
    chk("late_beat_wake", {24'd0, fill_wake}, 32'd0);
`ifdef ICACHE_PERF_EN
    chk("perf_hit_rst", perf_hit, 32'd0);
    chk("perf_miss_rst", perf_miss, 32'd0);
`endif
    fetch(32'h100, 3'd0);
    chk_resp("post_rst", 32'd0, 1'b1, 1'b0);
    serve(32'h100, 1'b1);
    expect_wake("post_rst_wake", 8'h01);
    fetch(32'h100, 3'd0);
    chk_resp("pr_hit0", mem_word(32'h100), 1'b0, 1'b0);
    fetch(32'h104, 3'd0);
    chk_resp("pr_hit1", mem_word(32'h104), 1'b0, 1'b0);
    fetch(32'h10C, 3'd0);
    chk_resp("pr_hit3", mem_word(32'h10C), 1'b0, 1'b0);
    fetch(32'h0002_0000, 3'd0);
    chk_resp("pr_seg", 32'd0, 1'b0, 1'b1);
    cyc();
`ifdef ICACHE_PERF_EN
    chk("perf_hit", perf_hit, 32'd3);
    chk("perf_miss", perf_miss, 32'd1);
`endif

    // Randomized stream against the resident-line model.
    inv_pulse();
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    last_data = 32'd0;
    for (int it = 0; it < 80; it++) begin
      k = $urandom_range(0, 11);
      if (k == 0) begin
        inv_pulse();
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
      end else if (k == 1) begin
        cyc();
        chk_resp("rnd_idle", last_data, 1'b0, 1'b0);
      end else begin
        if (k == 2)      a = 32'h0001_0000 + 32'($urandom_range(0, 4095) * 4);
        else if (k == 3) a = pool[$urandom_range(0, 5)] + 32'($urandom_range(1, 3));
        else             a = pool[$urandom_range(0, 5)] + 32'($urandom_range(0, 3) * 4);
        t = 3'($urandom_range(0, 7));
        exp_seg = (a >= 32'h0001_0000) || (a % 4 != 0);
        idx     = int'((a / 16) % 64);
        exp_hit = !exp_seg && mvalid[idx] && (mtag[idx] == a / 1024);
        exp_d   = exp_hit ? mem_word(a) : 32'd0;
        fetch(a, t);
        chk_resp("rnd", exp_d, !exp_seg && !exp_hit, exp_seg);
        last_data = exp_d;
        if (!exp_seg && !exp_hit) begin
          serve(a & ~32'hF, 1'b1);
          expect_wake("rnd_wake", 8'b1 << t);
          mvalid[idx] = 1'b1;
          mtag[idx]   = a / 1024;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
